// File: rtl/dbus_sram_responder.sv
// Data-bus responder: SRAM-backed 64-bit memory with programmable latency, one op in flight.
// Optional macro DBUS_RESP_RANDOM_DELAY_EN adds 0..3 LFSR-chosen extra edges per op.
package dbus_pkg;
  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    logic [2:0]  size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;
endpackage

module dbus_sram_responder
  import dbus_pkg::*;
#(
  parameter int          MEM_WORDS = 1024,
  parameter int          LATENCY   = 2,
  parameter logic [63:0] BASE_ADDR = 64'h8000_0000
) (
  input  logic       clk,
  input  logic       reset,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp
);

  localparam int          IDX_W = $clog2(MEM_WORDS);
  localparam logic [63:0] SPAN  = 64'(MEM_WORDS) << 3;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

  state_t      r_state;
  logic [4:0]  r_cnt;
  logic [63:0] r_addr;
  logic [7:0]  r_strobe;
  logic [63:0] r_data;

  logic [63:0] mem [MEM_WORDS];

  logic [4:0]       w_extra;
  logic [4:0]       w_total_m1;
  logic             w_direct;
  logic             w_sel_new;
  logic [63:0]      w_addr;
  logic [7:0]       w_strobe;
  logic [63:0]      w_wdata;
  logic [63:0]      w_off;
  logic             w_in_range;
  logic [IDX_W-1:0] w_idx;
  logic [63:0]      w_rword;
  logic [63:0]      w_merged;
  logic [63:0]      w_resp_data;
  logic             w_commit;
  logic             w_unused;

`ifdef DBUS_RESP_RANDOM_DELAY_EN
  logic [7:0] r_lfsr;

  // x^8+x^6+x^5+x^4+1, free-running so the extra delay varies op to op
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_lfsr <= 8'hA5;
    else        r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
  end

  assign w_extra = {3'b000, r_lfsr[1:0]};
`else
  assign w_extra = 5'd0;
`endif

  // Edges from sample to RESP entry, minus one; zero means go straight to RESP
  assign w_total_m1 = 5'(LATENCY - 1) + w_extra;
  assign w_direct   = (w_total_m1 == 5'd0);

  // The commit edge uses the live request when RESP is entered directly from IDLE
  assign w_sel_new = (r_state == S_IDLE);
  assign w_addr    = w_sel_new ? dreq.addr   : r_addr;
  assign w_strobe  = w_sel_new ? dreq.strobe : r_strobe;
  assign w_wdata   = w_sel_new ? dreq.data   : r_data;

  assign w_off      = w_addr - BASE_ADDR;
  assign w_in_range = (w_addr >= BASE_ADDR) && (w_off < SPAN);
  assign w_idx      = w_off[IDX_W+2:3];
  assign w_rword    = mem[w_idx];

  always_comb begin
    w_merged = w_rword;
    for (int i = 0; i < 8; i++) begin
      if (w_strobe[i]) w_merged[8*i +: 8] = w_wdata[8*i +: 8];
    end
  end

  assign w_resp_data = w_in_range ? w_merged : 64'd0;

  assign w_commit = reset && dreq.valid &&
                    (((r_state == S_IDLE) && w_direct) ||
                     ((r_state == S_BUSY) && (r_cnt == 5'd0)));

  assign w_unused = ^{dreq.size, w_off[63:IDX_W+3], w_off[2:0]};

  // Memory has no reset: contents survive a reset pulse
  always_ff @(posedge clk) begin
    if (w_commit && w_in_range && (|w_strobe)) mem[w_idx] <= w_merged;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= 5'd0;
      r_addr   <= 64'd0;
      r_strobe <= 8'd0;
      r_data   <= 64'd0;
      dresp    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          dresp <= '0;
          if (dreq.valid) begin
            r_addr   <= dreq.addr;
            r_strobe <= dreq.strobe;
            r_data   <= dreq.data;
            if (w_direct) begin
              r_state       <= S_RESP;
              dresp.addr_ok <= 1'b1;
              dresp.data_ok <= 1'b1;
              dresp.data    <= w_resp_data;
            end else begin
              r_state <= S_BUSY;
              r_cnt   <= w_total_m1 - 5'd1;
            end
          end
        end
        S_BUSY: begin
          // Initiator withdrew the request: drop the op without writing
          if (!dreq.valid) begin
            r_state <= S_IDLE;
            r_cnt   <= 5'd0;
          end else if (r_cnt == 5'd0) begin
            r_state       <= S_RESP;
            dresp.addr_ok <= 1'b1;
            dresp.data_ok <= 1'b1;
            dresp.data    <= w_resp_data;
          end else begin
            r_cnt <= r_cnt - 5'd1;
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
          dresp   <= '0;
        end
        default: begin
          r_state <= S_IDLE;
          dresp   <= '0;
        end
      endcase
    end
  end

endmodule
